// File: rtl/op_lut_fwd_sequencer_pkg.sv
// Shared definitions for the output-port-lookup forwarding sequencer.
// Holds the FSM encoding, the IOQ header constants and a log2 helper.
package op_lut_fwd_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MOD_HDRS = 2'd1,
    PAYLOAD  = 2'd2
  } state_t;

  localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff;
  localparam int         IOQ_DST_PORT_POS   = 0;

  // ceil(log2(n)) for n >= 1
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/op_lut_fwd_sequencer_if.sv
// Bus bundle around the sequencer: packet FIFO, parser and CAM results, output port, counters.
// slave = sequencer side, master = the surrounding datapath.
interface op_lut_fwd_sequencer_if #(
  parameter int DATA_WIDTH       = 64,
  parameter int CTRL_WIDTH       = DATA_WIDTH / 8,
  parameter int NUM_QUEUES       = 8,
  parameter int NUM_QUEUES_WIDTH = op_lut_fwd_sequencer_pkg::log2(NUM_QUEUES)
);
  logic [DATA_WIDTH-1:0]       in_fifo_data;
  logic [CTRL_WIDTH-1:0]       in_fifo_ctrl;
  logic                        in_fifo_empty;
  logic                        in_fifo_rd_en;
  logic                        is_from_cpu;
  logic [NUM_QUEUES-1:0]       to_cpu_output_port;
  logic [NUM_QUEUES-1:0]       from_cpu_output_port;
  logic [NUM_QUEUES_WIDTH-1:0] input_port_num;
  logic                        is_from_cpu_vld;
  logic                        rd_hdr_parser;
  logic [NUM_QUEUES-1:0]       lookup_dst_port;
  logic                        lookup_hit;
  logic                        lookup_vld;
  logic                        rd_lookup;
  logic [DATA_WIDTH-1:0]       out_data;
  logic [CTRL_WIDTH-1:0]       out_ctrl;
  logic                        out_wr;
  logic                        out_rdy;
  logic [31:0]                 pkt_fwd_cnt;
  logic [31:0]                 pkt_miss_cnt;

  modport slave (
    input  in_fifo_data, in_fifo_ctrl, in_fifo_empty,
    input  is_from_cpu, to_cpu_output_port, from_cpu_output_port, input_port_num, is_from_cpu_vld,
    input  lookup_dst_port, lookup_hit, lookup_vld, out_rdy,
    output in_fifo_rd_en, rd_hdr_parser, rd_lookup,
    output out_data, out_ctrl, out_wr, pkt_fwd_cnt, pkt_miss_cnt
  );

  modport master (
    output in_fifo_data, in_fifo_ctrl, in_fifo_empty,
    output is_from_cpu, to_cpu_output_port, from_cpu_output_port, input_port_num, is_from_cpu_vld,
    output lookup_dst_port, lookup_hit, lookup_vld, out_rdy,
    input  in_fifo_rd_en, rd_hdr_parser, rd_lookup,
    input  out_data, out_ctrl, out_wr, pkt_fwd_cnt, pkt_miss_cnt
  );

endinterface

// File: rtl/op_lut_dst_select.sv
// Combinational destination pick: CPU-sourced packets go to their MAC, CAM hits forward,
// misses / empty results / hairpins go to the CPU port paired with the source.
module op_lut_dst_select #(
  parameter int NUM_QUEUES       = 8,
  parameter int NUM_QUEUES_WIDTH = 3
) (
  input  logic                        is_from_cpu,
  input  logic [NUM_QUEUES-1:0]       to_cpu_output_port,
  input  logic [NUM_QUEUES-1:0]       from_cpu_output_port,
  input  logic [NUM_QUEUES_WIDTH-1:0] input_port_num,
  input  logic [NUM_QUEUES-1:0]       lookup_dst_port,
  input  logic                        lookup_hit,
  output logic [NUM_QUEUES-1:0]       dst_port,
  output logic                        fwd_inc,
  output logic                        miss_inc
);

  logic [NUM_QUEUES-1:0] src_dec;
  logic                  fwd_ok;

  always_comb begin
    src_dec  = NUM_QUEUES'(1) << input_port_num;
    // a hit pointing back at the source port is a hairpin and goes to the CPU
    fwd_ok   = lookup_hit && (|lookup_dst_port) && !(|(lookup_dst_port & src_dec));
    dst_port = to_cpu_output_port;
    fwd_inc  = 1'b0;
    miss_inc = 1'b0;
    if (is_from_cpu) begin
      dst_port = from_cpu_output_port;
    end else if (fwd_ok) begin
      dst_port = lookup_dst_port;
      fwd_inc  = 1'b1;
    end else begin
      miss_inc = 1'b1;
    end
  end

endmodule

// File: rtl/op_lut_fwd_sequencer.sv
// Output-port-lookup sequencer: pops parser + CAM results together, then streams the packet
// out with the IOQ header dst-port field rewritten. Output register has latency 1.
module op_lut_fwd_sequencer
  import op_lut_fwd_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH       = 64,
  parameter int CTRL_WIDTH       = DATA_WIDTH / 8,
  parameter int NUM_QUEUES       = 8,
  parameter int NUM_QUEUES_WIDTH = log2(NUM_QUEUES)
) (
  input logic                clk,
  input logic                reset,
  op_lut_fwd_sequencer_if.slave bus
);

  state_t                  state, state_nxt;
  logic [NUM_QUEUES-1:0]   dst_reg, dst_sel;
  logic                    fwd_sel, miss_sel;
  logic                    start, rd_en;
  logic [DATA_WIDTH-1:0]   word_mod;

  op_lut_dst_select #(
    .NUM_QUEUES       (NUM_QUEUES),
    .NUM_QUEUES_WIDTH (NUM_QUEUES_WIDTH)
  ) u_dst_select (
    .is_from_cpu          (bus.is_from_cpu),
    .to_cpu_output_port   (bus.to_cpu_output_port),
    .from_cpu_output_port (bus.from_cpu_output_port),
    .input_port_num       (bus.input_port_num),
    .lookup_dst_port      (bus.lookup_dst_port),
    .lookup_hit           (bus.lookup_hit),
    .dst_port             (dst_sel),
    .fwd_inc              (fwd_sel),
    .miss_inc             (miss_sel)
  );

  // pops are gated by reset so nothing is consumed while the block is being cleared
  always_comb begin
    start     = (state == IDLE) && !reset && !bus.in_fifo_empty &&
                bus.is_from_cpu_vld && bus.lookup_vld;
    rd_en     = (state != IDLE) && !reset && !bus.in_fifo_empty && bus.out_rdy;
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = MOD_HDRS;
      MOD_HDRS: if (rd_en && (bus.in_fifo_ctrl == '0)) state_nxt = PAYLOAD;
      PAYLOAD:  if (rd_en && (bus.in_fifo_ctrl != '0)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    word_mod = bus.in_fifo_data;
    if ((state == MOD_HDRS) && (bus.in_fifo_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM)))
      word_mod[IOQ_DST_PORT_POS +: 16] = 16'(dst_reg);
  end

  assign bus.rd_hdr_parser = start;
  assign bus.rd_lookup     = start;
  assign bus.in_fifo_rd_en = rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      dst_reg          <= '0;
      bus.out_data     <= '0;
      bus.out_ctrl     <= '0;
      bus.out_wr       <= 1'b0;
      bus.pkt_fwd_cnt  <= '0;
      bus.pkt_miss_cnt <= '0;
    end else begin
      state      <= state_nxt;
      bus.out_wr <= rd_en;
      if (start) begin
        dst_reg <= dst_sel;
        if (fwd_sel)  bus.pkt_fwd_cnt  <= bus.pkt_fwd_cnt + 32'd1;
        if (miss_sel) bus.pkt_miss_cnt <= bus.pkt_miss_cnt + 32'd1;
      end
      if (rd_en) begin
        bus.out_data <= word_mod;
        bus.out_ctrl <= bus.in_fifo_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_op_lut_fwd_sequencer.sv
// Directed bench for op_lut_fwd_sequencer: fallthrough FIFO and result FIFOs modelled with
// queues/flags, output words captured and compared against hand-derived packets.
module tb_op_lut_fwd_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  op_lut_fwd_sequencer_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_QUEUES(8), .NUM_QUEUES_WIDTH(3)) bus ();

  op_lut_fwd_sequencer #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_QUEUES(8), .NUM_QUEUES_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int hdr_pulses = 0;
  int lk_pulses = 0;
  int wr_seen = 0;
  logic toggle_rdy = 1'b0;
  logic [63:0] fifo_d[$];
  logic [7:0]  fifo_c[$];
  logic [63:0] out_d[$];
  logic [7:0]  out_c[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.in_fifo_empty = (fifo_d.size() == 0);
    bus.in_fifo_data  = (fifo_d.size() == 0) ? 64'h0 : fifo_d[0];
    bus.in_fifo_ctrl  = (fifo_c.size() == 0) ? 8'h0 : fifo_c[0];
  endtask

  // one clock: sample pops on the falling edge, apply them just after the rising edge
  task automatic cycle();
    logic rd, rh, rl;
    @(negedge clk);
    rd = bus.in_fifo_rd_en;
    rh = bus.rd_hdr_parser;
    rl = bus.rd_lookup;
    @(posedge clk);
    #1;
    if (rd && fifo_d.size() > 0) begin
      void'(fifo_d.pop_front());
      void'(fifo_c.pop_front());
    end
    if (rh) begin bus.is_from_cpu_vld = 1'b0; hdr_pulses++; end
    if (rl) begin bus.lookup_vld = 1'b0; lk_pulses++; end
    if (bus.out_wr) begin
      out_d.push_back(bus.out_data);
      out_c.push_back(bus.out_ctrl);
      wr_seen++;
    end
    drive_fifo();
    if (toggle_rdy) bus.out_rdy = ~bus.out_rdy;
  endtask

  // word 0 is the IOQ header, last word carries a nonzero ctrl as EOP
  task automatic load_pkt(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_d.push_back(base + 64'(i));
      fifo_c.push_back((i == 0) ? 8'hff : (i == n - 1) ? 8'h80 : 8'h00);
    end
    drive_fifo();
  endtask

  task automatic set_results(input logic fc, input logic [2:0] src, input logic [7:0] to_cpu,
                             input logic [7:0] from_cpu, input logic [7:0] lk, input logic hit,
                             input logic lv);
    bus.is_from_cpu          = fc;
    bus.input_port_num       = src;
    bus.to_cpu_output_port   = to_cpu;
    bus.from_cpu_output_port = from_cpu;
    bus.lookup_dst_port      = lk;
    bus.lookup_hit           = hit;
    bus.is_from_cpu_vld      = 1'b1;
    bus.lookup_vld           = lv;
  endtask

  task automatic run_until(input int n);
    int budget;
    budget = 300;
    while (out_d.size() < n && budget > 0) begin
      cycle();
      budget--;
    end
  endtask

  task automatic check_pkt(input string tag, input int n, input logic [63:0] base, input logic [15:0] dst);
    logic [63:0] ed;
    logic [7:0]  ec;
    chk({tag, "_len"}, 64'(out_d.size()), 64'(n));
    for (int i = 0; i < n && i < out_d.size(); i++) begin
      ed = (i == 0) ? {base[63:16], dst} : base + 64'(i);
      ec = (i == 0) ? 8'hff : (i == n - 1) ? 8'h80 : 8'h00;
      chk($sformatf("%s_d%0d", tag, i), out_d[i], ed);
      chk($sformatf("%s_c%0d", tag, i), 64'(out_c[i]), 64'(ec));
    end
    out_d.delete();
    out_c.delete();
  endtask

  initial begin
    bus.out_rdy = 1'b1;
    set_results(1'b0, 3'd0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    bus.is_from_cpu_vld = 1'b0;
    drive_fifo();
    repeat (3) cycle();
    chk("rst_out_wr", 64'(bus.out_wr), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_fwd_cnt", 64'(bus.pkt_fwd_cnt), 64'd0);
    chk("rst_miss_cnt", 64'(bus.pkt_miss_cnt), 64'd0);
    reset = 1'b0;

    // 1: from CPU, lookup hit ignored, no counter change
    hdr_pulses = 0; lk_pulses = 0;
    load_pkt(4, 64'h1111_2222_3333_ffff);
    set_results(1'b1, 3'd1, 8'h02, 8'h01, 8'h04, 1'b1, 1'b1);
    run_until(4);
    check_pkt("cpu", 4, 64'h1111_2222_3333_ffff, 16'h0001);
    chk("cpu_hdr_pulses", 64'(hdr_pulses), 64'd1);
    chk("cpu_lk_pulses", 64'(lk_pulses), 64'd1);
    chk("cpu_fwd_cnt", 64'(bus.pkt_fwd_cnt), 64'd0);
    chk("cpu_miss_cnt", 64'(bus.pkt_miss_cnt), 64'd0);

    // 2: CAM hit
    load_pkt(3, 64'haaaa_0000_0000_1234);
    set_results(1'b0, 3'd0, 8'h02, 8'h01, 8'h04, 1'b1, 1'b1);
    run_until(3);
    check_pkt("hit", 3, 64'haaaa_0000_0000_1234, 16'h0004);
    chk("hit_fwd_cnt", 64'(bus.pkt_fwd_cnt), 64'd1);
    chk("hit_miss_cnt", 64'(bus.pkt_miss_cnt), 64'd0);

    // 3: miss then hairpin, both to CPU port 0x08
    load_pkt(3, 64'h5555_0000_0000_0000);
    set_results(1'b0, 3'd2, 8'h08, 8'h04, 8'h00, 1'b0, 1'b1);
    run_until(3);
    check_pkt("miss", 3, 64'h5555_0000_0000_0000, 16'h0008);
    load_pkt(3, 64'h6666_0000_0000_0000);
    set_results(1'b0, 3'd2, 8'h08, 8'h04, 8'h04, 1'b1, 1'b1);
    run_until(3);
    check_pkt("hairpin", 3, 64'h6666_0000_0000_0000, 16'h0008);
    chk("hairpin_miss_cnt", 64'(bus.pkt_miss_cnt), 64'd2);
    chk("hairpin_fwd_cnt", 64'(bus.pkt_fwd_cnt), 64'd1);

    // 4: backpressure with out_rdy toggling every cycle
    wr_seen = 0;
    toggle_rdy = 1'b1;
    load_pkt(8, 64'h0123_4567_89ab_cdef);
    set_results(1'b0, 3'd0, 8'h02, 8'h01, 8'h10, 1'b1, 1'b1);
    run_until(8);
    repeat (4) cycle();
    toggle_rdy = 1'b0;
    bus.out_rdy = 1'b1;
    chk("bp_wr_pulses", 64'(wr_seen), 64'd8);
    check_pkt("bp", 8, 64'h0123_4567_89ab_cdef, 16'h0010);
    chk("bp_fwd_cnt", 64'(bus.pkt_fwd_cnt), 64'd2);

    // 5: CAM result missing for 10 cycles
    hdr_pulses = 0; wr_seen = 0;
    load_pkt(3, 64'h7777_0000_0000_0000);
    set_results(1'b0, 3'd4, 8'h02, 8'h01, 8'h40, 1'b1, 1'b0);
    repeat (10) cycle();
    chk("stall_hdr_pulses", 64'(hdr_pulses), 64'd0);
    chk("stall_wr", 64'(wr_seen), 64'd0);
    chk("stall_fifo_level", 64'(fifo_d.size()), 64'd3);
    bus.lookup_vld = 1'b1;
    #1;
    chk("resume_rd_lookup", 64'(bus.rd_lookup), 64'd1);
    chk("resume_rd_hdr", 64'(bus.rd_hdr_parser), 64'd1);
    run_until(3);
    check_pkt("resume", 3, 64'h7777_0000_0000_0000, 16'h0040);
    chk("resume_fwd_cnt", 64'(bus.pkt_fwd_cnt), 64'd3);

    // 6: reset after three output words
    load_pkt(8, 64'h9999_0000_0000_0000);
    set_results(1'b0, 3'd0, 8'h02, 8'h01, 8'h02, 1'b1, 1'b1);
    run_until(3);
    chk("abort_pre_fwd_cnt", 64'(bus.pkt_fwd_cnt), 64'd4);
    reset = 1'b1;
    cycle();
    chk("abort_out_wr", 64'(bus.out_wr), 64'd0);
    chk("abort_out_data", bus.out_data, 64'd0);
    chk("abort_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("abort_fwd_cnt", 64'(bus.pkt_fwd_cnt), 64'd0);
    chk("abort_miss_cnt", 64'(bus.pkt_miss_cnt), 64'd0);
    chk("abort_rd_en", 64'(bus.in_fifo_rd_en), 64'd0);
    reset = 1'b0;
    #1;
    chk("abort_idle_no_rd", 64'(bus.in_fifo_rd_en), 64'd0);
    set_results(1'b0, 3'd0, 8'h02, 8'h01, 8'h02, 1'b1, 1'b1);
    #1;
    chk("abort_idle_start", 64'(bus.rd_hdr_parser), 64'd1);
    bus.is_from_cpu_vld = 1'b0;
    bus.lookup_vld = 1'b0;
    fifo_d.delete();
    fifo_c.delete();
    drive_fifo();
    out_d.delete();
    out_c.delete();
    repeat (2) cycle();
    chk("abort_no_wr", 64'(out_d.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
